soc_trace: RTL

SOC_TRACE -- requirements
Module: soc_trace

---
 rtl/soc_trace_pkg.sv | 24 ++
 rtl/trace_fifo.sv | 47 ++++
 rtl/soc_trace.sv | 138 +++++++++++++
 3 files changed

// File: rtl/soc_trace_pkg.sv
// Shared types and constants for the SoC trace capture block.
// Records are 72 bits: tag byte, word A, word B, serialized MSB-first as 9 bytes.
package soc_trace_pkg;

    localparam int         REC_W       = 72;
    localparam int         NBYTES      = 9;
    localparam logic [7:0] TAG_MEM_DEF = 8'hA5;
    localparam logic [7:0] TAG_EXC_DEF = 8'hE0;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_t;

    typedef logic [REC_W-1:0] rec_t;

    // Byte idx of a record, counting from the tag byte at idx 0.
    function automatic logic [7:0] rec_byte(input rec_t rec, input logic [3:0] idx);
        rec_t sh;
        sh = rec << {idx, 3'b000};
        return sh[REC_W-1 -: 8];
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous record FIFO, DEPTH entries, registered pointers, head visible combinationally.
// Latency: push visible at head next cycle; push into a full FIFO is accepted only alongside a pop.
module trace_fifo #(
    parameter int W     = 72,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [W-1:0]             i_push_dat,
    input  logic                     i_pop,
    output logic [W-1:0]             o_head_dat,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_cnt
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_push_ok;
    logic         w_pop_ok;

    assign o_cnt      = r_wr_ptr - r_rd_ptr;
    assign o_full     = (o_cnt == (AW+1)'(DEPTH));
    assign o_empty    = (o_cnt == '0);
    assign o_head_dat = r_mem[r_rd_ptr[AW-1:0]];
    assign w_pop_ok   = i_pop && !o_empty;
    assign w_push_ok  = i_push && (!o_full || w_pop_ok);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
    end

endmodule

// File: rtl/soc_trace.sv
// Captures RAM-bus and CP0 exception-vector changes as 9-byte records, streamed over valid/ready.
// First byte valid the cycle after capture; tx_ready low stalls the byte, a full FIFO drops new records.
module soc_trace
    import soc_trace_pkg::*;
#(
    parameter int         DEPTH   = 4,
    parameter logic [7:0] TAG_MEM = TAG_MEM_DEF,
    parameter logic [7:0] TAG_EXC = TAG_EXC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cap_en,
    input  logic [31:0] ram_addr,
    input  logic [31:0] ram_data,
    input  logic [31:0] cp0_exc_addr,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        overflow,
    output logic [15:0] dropped_cnt
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] LAST_IDX = 4'(NBYTES - 1);

    logic [31:0] r_last_addr;
    logic [31:0] r_last_data;
    logic [31:0] r_last_exc;
    logic        r_overflow;
    logic [15:0] r_dropped;
    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_idx;
    logic [3:0]  w_idx_nxt;

    logic        w_exc_chg;
    logic        w_mem_chg;
    logic        w_push;
    logic        w_push_acc;
    logic        w_pop;
    logic        w_drop;
    logic        w_full;
    logic        w_empty;
    logic        w_nonempty_nxt;
    logic [AW:0] w_cnt;
    rec_t        w_rec;
    rec_t        w_head;

    // Exception changes take priority; a pending memory change is retried next cycle.
    assign w_exc_chg  = cap_en && (cp0_exc_addr != r_last_exc);
    assign w_mem_chg  = cap_en && !w_exc_chg && ({ram_addr, ram_data} != {r_last_addr, r_last_data});
    assign w_push     = w_exc_chg || w_mem_chg;
    assign w_rec      = w_exc_chg ? {TAG_EXC, cp0_exc_addr, 32'h0} : {TAG_MEM, ram_addr, ram_data};
    assign w_pop      = (r_state == ST_SEND) && tx_ready && (r_idx == LAST_IDX);
    assign w_push_acc = w_push && (!w_full || w_pop);
    assign w_drop     = w_push && !w_push_acc;
    assign w_nonempty_nxt = w_push_acc || (w_cnt > (AW+1)'(1)) ||
                            ((w_cnt == (AW+1)'(1)) && !w_pop);

    trace_fifo #(
        .W     (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_push),
        .i_push_dat (w_rec),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_cnt      (w_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_addr <= '0;
            r_last_data <= '0;
            r_last_exc  <= '0;
            r_overflow  <= 1'b0;
            r_dropped   <= '0;
        end else begin
            if (w_exc_chg) begin
                r_last_exc <= cp0_exc_addr;
            end else if (w_mem_chg) begin
                r_last_addr <= ram_addr;
                r_last_data <= ram_data;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_dropped != 16'hFFFF) r_dropped <= r_dropped + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        case (r_state)
            ST_IDLE: begin
                // Enter SEND on the push edge so the tag byte is valid the very next cycle.
                if (!w_empty || w_push_acc) begin
                    w_state_nxt = ST_SEND;
                    w_idx_nxt   = '0;
                end
            end
            ST_SEND: begin
                tx_valid = 1'b1;
                tx_data  = rec_byte(w_head, r_idx);
                if (tx_ready) begin
                    if (r_idx == LAST_IDX) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = w_nonempty_nxt ? ST_SEND : ST_IDLE;
                    end else begin
                        w_idx_nxt = r_idx + 4'd1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign overflow    = r_overflow;
    assign dropped_cnt = r_dropped;

endmodule
